// File: rtl/thunderbird_lamp_decoder.sv
// Decodes the six tail-light outputs of the Thunderbird turn-signal FSM back into the turn command.
// It tracks the lamp sequence, reports direction, counts completed sequences and flags illegal patterns.
module thunderbird_lamp_decoder #(
    parameter int SEQ_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    output logic             dir_left,
    output logic             dir_right,
    output logic             seq_done,
    output logic             err,
    output logic [1:0]       last_dir,
    output logic [SEQ_W-1:0] seq_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3} state_t;

    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_L1  = 6'b100000;
    localparam logic [5:0] P_L2  = 6'b110000;
    localparam logic [5:0] P_L3  = 6'b111000;
    localparam logic [5:0] P_R1  = 6'b000100;
    localparam logic [5:0] P_R2  = 6'b000110;
    localparam logic [5:0] P_R3  = 6'b000111;

    state_t     state;
    state_t     next_state;
    logic       legal;
    logic       done;
    logic [5:0] p;

    assign p = {la, lb, lc, ra, rb, rc};

    always_comb begin
        next_state = IDLE;
        legal      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (p == P_OFF) begin
                    legal = 1'b1;
                    next_state = IDLE;
                end else if (p == P_L1) begin
                    legal = 1'b1;
                    next_state = L1;
                end else if (p == P_R1) begin
                    legal = 1'b1;
                    next_state = R1;
                end
            end
            L1: if (p == P_L2) begin legal = 1'b1; next_state = L2; end
            L2: if (p == P_L3) begin legal = 1'b1; next_state = L3; end
            L3: if (p == P_OFF) begin legal = 1'b1; done = 1'b1; next_state = IDLE; end
            R1: if (p == P_R2) begin legal = 1'b1; next_state = R2; end
            R2: if (p == P_R3) begin legal = 1'b1; next_state = R3; end
            R3: if (p == P_OFF) begin legal = 1'b1; done = 1'b1; next_state = IDLE; end
            default: ;
        endcase
        // An illegal pattern that happens to be a sequence start is taken as a fresh start.
        if (!legal) begin
            if (p == P_L1)      next_state = L1;
            else if (p == P_R1) next_state = R1;
            else                next_state = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dir_left  <= 1'b0;
            dir_right <= 1'b0;
            seq_done  <= 1'b0;
            err       <= 1'b0;
            last_dir  <= 2'b00;
            seq_count <= '0;
            err_count <= '0;
        end else begin
            state     <= next_state;
            dir_left  <= (next_state == L1) || (next_state == L2) || (next_state == L3);
            dir_right <= (next_state == R1) || (next_state == R2) || (next_state == R3);
            seq_done  <= done;
            err       <= !legal;
            if (done) begin
                seq_count <= seq_count + SEQ_W'(1);
                last_dir  <= (state == L3) ? 2'b01 : 2'b10;
            end
            if (!legal && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_thunderbird_lamp_decoder.sv
// Scoreboard bench for thunderbird_lamp_decoder: directed lamp sequences plus biased random patterns,
// run on a default-width instance and a 2-bit-counter instance driven by the same lamps.
module tb_thunderbird_lamp_decoder;

    logic clk;
    logic reset;
    logic la, lb, lc, ra, rb, rc;

    logic       dl8, dr8, sd8, er8;
    logic [1:0] ld8;
    logic [7:0] seq8, err8;
    logic       dl2, dr2, sd2, er2;
    logic [1:0] ld2;
    logic [1:0] seq2, err2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];

    // Reference model: which side is lit and how many lamps, plus plain integer counters.
    int m_side, m_n, m_last, m_seq, m_err;

    thunderbird_lamp_decoder dut8 (
        .clk(clk), .reset(reset),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .dir_left(dl8), .dir_right(dr8), .seq_done(sd8), .err(er8),
        .last_dir(ld8), .seq_count(seq8), .err_count(err8)
    );

    thunderbird_lamp_decoder #(.SEQ_W(2), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .dir_left(dl2), .dir_right(dr2), .seq_done(sd2), .err(er2),
        .last_dir(ld2), .seq_count(seq2), .err_count(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lamps(input int side, input int n);
        logic [2:0] b;
        b = 3'(7 << (3 - n));
        if (side == 1) return {b, 3'b000};
        if (side == 2) return {3'b000, b};
        return 6'b000000;
    endfunction

    function automatic logic [31:0] actual();
        return {dl8, dr8, sd8, er8, ld8, seq8, err8, dl2, dr2, sd2, er2, ld2, seq2, err2};
    endfunction

    function automatic logic [31:0] expected(input bit done, input bit bad);
        logic [5:0] flags;
        flags = {m_side == 1, m_side == 2, done, bad, 2'(m_last)};
        return {flags, 8'(m_seq % 256), 8'(m_err > 255 ? 255 : m_err),
                flags, 2'(m_seq % 4), 2'(m_err > 3 ? 3 : m_err)};
    endfunction

    task automatic model_reset();
        m_side = 0; m_n = 0; m_last = 0; m_seq = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [5:0] p);
        bit ok, done;
        ok = 1'b0;
        done = 1'b0;
        if (m_side == 0) begin
            if (p == 6'b0) ok = 1'b1;
            else if (p == lamps(1, 1)) begin ok = 1'b1; m_side = 1; m_n = 1; end
            else if (p == lamps(2, 1)) begin ok = 1'b1; m_side = 2; m_n = 1; end
        end else if (m_n < 3) begin
            if (p == lamps(m_side, m_n + 1)) begin ok = 1'b1; m_n++; end
        end else if (p == 6'b0) begin
            ok = 1'b1; done = 1'b1;
            m_last = m_side; m_seq++; m_side = 0; m_n = 0;
        end
        if (!ok) begin
            m_err++;
            if (p == lamps(1, 1))      begin m_side = 1; m_n = 1; end
            else if (p == lamps(2, 1)) begin m_side = 2; m_n = 1; end
            else                       begin m_side = 0; m_n = 0; end
        end
        exp_q.push_back(expected(done, !ok));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic [5:0] p);
        {la, lb, lc, ra, rb, rc} = p;
        model_step(p);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (actual() !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset outputs act=%h exp=%h", actual(), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [5:0] pick_legal();
        int r;
        if (m_side == 0) begin
            r = $urandom_range(0, 2);
            return (r == 0) ? 6'b0 : lamps(r, 1);
        end
        if (m_n < 3) return lamps(m_side, m_n + 1);
        return 6'b0;
    endfunction

    // Monitor: every cycle the DUT presents a new registered output set.
    always begin
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (actual() !== e) begin
                n_fail++;
                $display("FAIL cycle %0d outputs act=%h exp=%h", cyc, actual(), e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {la, lb, lc, ra, rb, rc} = 6'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (actual() !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state act=%h exp=%h", actual(), 32'h0);
        end
        reset = 1'b0;

        // Left sequence
        drive(6'b000000); drive(6'b100000); drive(6'b110000); drive(6'b111000); drive(6'b000000);
        // Right sequence three times
        repeat (3) begin
            drive(6'b000100); drive(6'b000110); drive(6'b000111); drive(6'b000000);
        end
        // Illegal: skipped L2, then both sides lit
        drive(6'b100000); drive(6'b111000); drive(6'b101100); drive(6'b000000);
        // Resync on a repeated start
        drive(6'b100000); drive(6'b110000); drive(6'b100000); drive(6'b110000);
        drive(6'b111000); drive(6'b000000);
        // Reset while in L2
        drive(6'b100000); drive(6'b110000);
        async_reset();
        // Mid-sequence pattern straight after reset
        drive(6'b110000); drive(6'b000000);
        // Five errors then five left sequences: saturation and wrap of the narrow counters
        repeat (5) drive(6'b010000);
        drive(6'b000000);
        repeat (5) begin
            drive(6'b100000); drive(6'b110000); drive(6'b111000); drive(6'b000000);
        end
        // Right-side hold is illegal
        drive(6'b000100); drive(6'b000100); drive(6'b000000);

        // Random: mostly legal progress, occasional arbitrary pattern or reset
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) async_reset();
            else if (r < 200) drive(6'($urandom_range(0, 63)));
            else drive(pick_legal());
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
